// File: rtl/traffic_light_ctrl_2way.sv
// Two-road intersection controller: road A rests in green, road B is served on demand.
// Define TLC_FLASH_EN to enable the flashing night mode requested through flash_req.
module traffic_light_ctrl_2way #(
    parameter int GREEN_A_CYCLES    = 10,
    parameter int GREEN_B_CYCLES    = 10,
    parameter int YELLOW_CYCLES     = 3,
    parameter int ALLRED_CYCLES     = 2,
    parameter int FLASH_HALF_CYCLES = 4,
    parameter int TIMER_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_b,
    input  logic       ped_req,
    input  logic       flash_req,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALLRED_BA = 3'd0,
        A_GREEN   = 3'd1,
        A_YELLOW  = 3'd2,
        ALLRED_AB = 3'd3,
        B_GREEN   = 3'd4,
        B_YELLOW  = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] GA_LAST = TIMER_W'(GREEN_A_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GB_LAST = TIMER_W'(GREEN_B_CYCLES - 1);
    localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(ALLRED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FH_LAST = TIMER_W'(FLASH_HALF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               demand;
    logic               ped_pend;
    logic               walk_q;
    logic               enter_b;
    logic               flash_go;

`ifdef TLC_FLASH_EN
    logic flash_pend;
    logic toggle;
    logic enter_flash;

    // A request seen anywhere is held until the next all-red interval expires.
    assign flash_go    = flash_pend | flash_req;
    assign enter_flash = (state_next == FLASH) && (state != FLASH);
`else
    logic flash_unused;

    assign flash_go     = 1'b0;
    assign flash_unused = flash_req;
`endif

    assign enter_b = (state_next == B_GREEN) && (state != B_GREEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALLRED_BA;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ALLRED_BA: if (timer == AR_LAST) state_next = flash_go ? FLASH : A_GREEN;
            A_GREEN:   if (timer == GA_LAST && demand) state_next = A_YELLOW;
            A_YELLOW:  if (timer == Y_LAST) state_next = ALLRED_AB;
            ALLRED_AB: if (timer == AR_LAST) state_next = flash_go ? FLASH : B_GREEN;
            B_GREEN:   if (timer == GB_LAST) state_next = B_YELLOW;
            B_YELLOW:  if (timer == Y_LAST) state_next = ALLRED_BA;
`ifdef TLC_FLASH_EN
            FLASH:     if (timer == FH_LAST && !flash_req) state_next = ALLRED_BA;
`endif
            default:   state_next = ALLRED_BA;
        endcase
    end

    // A green holds its timer at the minimum once reached; flash restarts it each half period.
    always_comb begin
        if (state_next != state) begin
            timer_next = '0;
        end else if (state == A_GREEN && timer == GA_LAST) begin
            timer_next = timer;
        end else if (state == FLASH && timer == FH_LAST) begin
            timer_next = '0;
        end else begin
            timer_next = timer + TIMER_ONE;
        end
    end

    // Set beats clear so a request arriving on B-green entry is served next round.
    always_ff @(posedge clk) begin
        if (rst) begin
            demand   <= 1'b0;
            ped_pend <= 1'b0;
            walk_q   <= 1'b0;
        end else begin
            if (sensor_b || ped_req) begin
                demand <= 1'b1;
            end else if (enter_b) begin
                demand <= 1'b0;
            end
            if (ped_req) begin
                ped_pend <= 1'b1;
            end else if (enter_b) begin
                ped_pend <= 1'b0;
            end
            if (enter_b) begin
                walk_q <= ped_pend;
            end
        end
    end

`ifdef TLC_FLASH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_pend <= 1'b0;
            toggle     <= 1'b0;
        end else begin
            if (state == FLASH || state_next == FLASH) begin
                flash_pend <= 1'b0;
            end else if (flash_req) begin
                flash_pend <= 1'b1;
            end
            if (enter_flash) begin
                toggle <= 1'b0;
            end else if (state == FLASH && timer == FH_LAST) begin
                toggle <= ~toggle;
            end
        end
    end
`endif

    always_comb begin
        light_a = LAMP_RED;
        light_b = LAMP_RED;
        walk    = 1'b0;
        case (state)
            A_GREEN:  light_a = LAMP_GRN;
            A_YELLOW: light_a = LAMP_YEL;
            B_GREEN: begin
                light_b = LAMP_GRN;
                walk    = walk_q;
            end
            B_YELLOW: light_b = LAMP_YEL;
`ifdef TLC_FLASH_EN
            FLASH: begin
                light_a = toggle ? LAMP_YEL : LAMP_OFF;
                light_b = toggle ? LAMP_RED : LAMP_OFF;
            end
`endif
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl_2way.sv
// Bench for traffic_light_ctrl_2way: phase/age model checked every cycle plus directed literal checks.
module tb_traffic_light_ctrl_2way;

    localparam int GREEN_A    = 10;
    localparam int GREEN_B    = 10;
    localparam int YELLOW     = 3;
    localparam int ALLRED     = 2;
    localparam int FLASH_HALF = 4;

`ifdef TLC_FLASH_EN
    localparam bit FLASH_BUILD = 1'b1;
`else
    localparam bit FLASH_BUILD = 1'b0;
`endif

    localparam int P_ARBA = 0, P_AG = 1, P_AY = 2, P_ARAB = 3, P_BG = 4, P_BY = 5, P_FL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor_b = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_req = 1'b0;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       walk;
    logic [2:0] phase;

    traffic_light_ctrl_2way #(
        .GREEN_A_CYCLES(GREEN_A), .GREEN_B_CYCLES(GREEN_B), .YELLOW_CYCLES(YELLOW),
        .ALLRED_CYCLES(ALLRED), .FLASH_HALF_CYCLES(FLASH_HALF), .TIMER_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sensor_b(sensor_b), .ped_req(ped_req), .flash_req(flash_req),
        .light_a(light_a), .light_b(light_b), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Model: phase plus cycles spent in it; durations come straight from the rules.
    typedef struct packed {
        int ph;
        int age;
        bit dem;
        bit ped;
        bit wk;
        bit fpend;
    } mdl_t;

    function automatic mdl_t model_step(mdl_t m, bit r, bit s, bit p, bit f);
        mdl_t n;
        int   nxt;
        int   lasted;
        bit   enter_b;
        bit   fgo;
        n = '0;
        if (r) return n;
        lasted = m.age + 1;
        nxt = m.ph;
        fgo = FLASH_BUILD && (m.fpend || f);
        case (m.ph)
            P_ARBA: if (lasted >= ALLRED) nxt = fgo ? P_FL : P_AG;
            P_AG:   if (lasted >= GREEN_A && m.dem) nxt = P_AY;
            P_AY:   if (lasted >= YELLOW) nxt = P_ARAB;
            P_ARAB: if (lasted >= ALLRED) nxt = fgo ? P_FL : P_BG;
            P_BG:   if (lasted >= GREEN_B) nxt = P_BY;
            P_BY:   if (lasted >= YELLOW) nxt = P_ARBA;
            P_FL:   if ((lasted % FLASH_HALF) == 0 && !f) nxt = P_ARBA;
            default: nxt = P_ARBA;
        endcase
        enter_b = (nxt == P_BG) && (m.ph != P_BG);
        n.ph = nxt;
        n.age = (nxt != m.ph) ? 0 : lasted;
        n.dem = (s || p) ? 1'b1 : (enter_b ? 1'b0 : m.dem);
        n.ped = p ? 1'b1 : (enter_b ? 1'b0 : m.ped);
        n.wk = enter_b ? m.ped : m.wk;
        n.fpend = (m.ph == P_FL || nxt == P_FL) ? 1'b0 : (m.fpend || f);
        return n;
    endfunction

    function automatic logic [9:0] model_out(mdl_t m);
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
        bit         tog;
        a = 3'b100;
        b = 3'b100;
        w = 1'b0;
        tog = ((m.age / FLASH_HALF) % 2) == 1;
        case (m.ph)
            P_AG: a = 3'b001;
            P_AY: a = 3'b010;
            P_BG: begin
                b = 3'b001;
                w = m.wk;
            end
            P_BY: b = 3'b010;
            P_FL: begin
                a = tog ? 3'b010 : 3'b000;
                b = tog ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        return {a, b, w, 3'(m.ph)};
    endfunction

    mdl_t m = '0;
    bit   m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) m_valid = 1'b1;
            m = model_step(m, rst, sensor_b, ped_req, flash_req);
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e = model_out(m);
                check("cmp light_a", int'(light_a), int'(e[9:7]));
                check("cmp light_b", int'(light_b), int'(e[6:4]));
                check("cmp walk", int'(walk), int'(e[3]));
                check("cmp phase", int'(phase), int'(e[2:0]));
            end
        end
    end

    // Run-length log of observed phases for the duration checks.
    typedef struct {
        int ph;
        int len;
        int wk;
    } run_t;
    run_t runs[$];

    initial begin
        int   prev;
        int   len;
        int   wk;
        run_t r;
        prev = 7;
        len = 0;
        wk = 0;
        forever begin
            @(negedge clk);
            if (int'(phase) != prev) begin
                if (len > 0) begin
                    r.ph = prev;
                    r.len = len;
                    r.wk = wk;
                    runs.push_back(r);
                end
                prev = int'(phase);
                len = 0;
                wk = 0;
            end
            len++;
            wk += int'(walk);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench at cycle 0: rst just released, DUT in ALLRED_BA with timer 0.
    task automatic reset_dut();
        rst = 1'b1;
        sensor_b = 1'b0;
        ped_req = 1'b0;
        flash_req = 1'b0;
        ticks(2);
        runs.delete();
        rst = 1'b0;
    endtask

    task automatic check_cycle(input string tag, input int exp_walk);
        int exp_ph[6]  = '{1, 2, 3, 4, 5, 0};
        int exp_len[6] = '{10, 3, 2, 10, 3, 2};
        if (runs.size() < 7) begin
            check({tag, " run count"}, runs.size(), 7);
            return;
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s phase[%0d]", tag, i), runs[i + 1].ph, exp_ph[i]);
            check($sformatf("%s length[%0d]", tag, i), runs[i + 1].len, exp_len[i]);
        end
        check({tag, " walk cycles"}, runs[4].wk, exp_walk);
        check({tag, " back to A green"}, int'(phase), 1);
    endtask

    initial begin
        int sum;

        // Reset state and idle A green
        rst = 1'b1;
        ticks(2);
        check("reset light_a", int'(light_a), 4);
        check("reset light_b", int'(light_b), 4);
        check("reset walk", int'(walk), 0);
        check("reset phase", int'(phase), 0);
        reset_dut();
        check("t1 c0 light_a", int'(light_a), 4);
        tick();
        check("t1 c1 light_a", int'(light_a), 4);
        check("t1 c1 light_b", int'(light_b), 4);
        tick();
        check("t1 c2 light_a", int'(light_a), 1);
        ticks(49);
        check("t1 c51 light_a", int'(light_a), 1);
        check("t1 c51 light_b", int'(light_b), 4);

        // sensor pulse in the 5th A-green cycle
        reset_dut();
        ticks(6);
        sensor_b = 1'b1;
        tick();
        sensor_b = 1'b0;
        ticks(29);
        check_cycle("t2", 0);

        // pedestrian pulse gives walk for all of B green
        reset_dut();
        ticks(6);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        ticks(29);
        check_cycle("t3", 10);

        // continuous sensor: fixed 30-cycle period
        reset_dut();
        sensor_b = 1'b1;
        ticks(96);
        sensor_b = 1'b0;
        if (runs.size() < 19) begin
            check("t4 run count", runs.size(), 19);
        end else begin
            for (int p = 0; p < 3; p++) begin
                check($sformatf("t4 A phase p%0d", p), runs[1 + 6 * p].ph, 1);
                check($sformatf("t4 A length p%0d", p), runs[1 + 6 * p].len, 10);
                sum = 0;
                for (int k = 1; k <= 6; k++) sum += runs[k + 6 * p].len;
                check($sformatf("t4 period p%0d", p), sum, 30);
            end
        end

        // reset in B green (timer 4) with demand re-latched
        reset_dut();
        ticks(2);
        sensor_b = 1'b1;
        tick();
        sensor_b = 1'b0;
        ticks(16);
        sensor_b = 1'b1;
        tick();
        sensor_b = 1'b0;
        tick();
        check("t5 c21 phase", int'(phase), 4);
        rst = 1'b1;
        tick();
        check("t5 rst light_a", int'(light_a), 4);
        check("t5 rst light_b", int'(light_b), 4);
        check("t5 rst phase", int'(phase), 0);
        check("t5 rst walk", int'(walk), 0);
        rst = 1'b0;
        tick();
        check("t5 +1 phase", int'(phase), 0);
        tick();
        check("t5 +2 phase", int'(phase), 1);
        ticks(15);
        check("t5 demand discarded", int'(phase), 1);

`ifdef TLC_FLASH_EN
        // flash mode entered after ALLRED_AB, exits through ALLRED_BA
        reset_dut();
        ticks(3);
        sensor_b = 1'b1;
        tick();
        sensor_b = 1'b0;
        flash_req = 1'b1;
        ticks(13);
        check("t6 c17 phase", int'(phase), 6);
        check("t6 c17 light_a", int'(light_a), 0);
        check("t6 c17 light_b", int'(light_b), 0);
        ticks(4);
        check("t6 c21 light_a", int'(light_a), 2);
        check("t6 c21 light_b", int'(light_b), 4);
        ticks(4);
        check("t6 c25 light_a", int'(light_a), 0);
        ticks(2);
        flash_req = 1'b0;
        ticks(2);
        check("t6 c29 phase", int'(phase), 0);
        tick();
        check("t6 c30 phase", int'(phase), 0);
        tick();
        check("t6 c31 phase", int'(phase), 1);
        ticks(10);
        check("t6 c41 phase", int'(phase), 2);
`endif

        ticks(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
